// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_pkg
//  Description : Shared types and constants for the instruction-fetch front
//                end (fetch state encoding, opcode width, NOP/HALT words).
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

    localparam int OPCODE_W = 9;

    // Fetch sequencer states, explicitly encoded in three bits.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } fetch_state_t;

    // Word presented to Control whenever no real instruction is on OPCODE.
    localparam logic [OPCODE_W-1:0] NOP_OPCODE  = 9'h000;

    // Encoding of the HALT instruction; used by test environments to build ROMs.
    localparam logic [OPCODE_W-1:0] HALT_OPCODE = 9'b0_0110_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_if
//  Description : Bundle of the fetch front end's ROM, Control and datapath
//                signals. The master side is the fetch sequencer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
);
    import fetch_sequencer_pkg::*;

    logic                start;
    logic [PC_W-1:0]     start_addr;
    logic [PC_W-1:0]     iaddr;
    logic [OPCODE_W-1:0] idata;
    logic [OPCODE_W-1:0] opcode;
    logic                instr_valid;
    logic                branch_taken;
    logic [PC_W-1:0]     branch_target;
    logic                halt;
    logic                done;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        input  start, start_addr, idata, branch_taken, branch_target, halt,
        output iaddr, opcode, instr_valid, done, instr_count
    );

    modport slave (
        output start, start_addr, idata, branch_taken, branch_target, halt,
        input  iaddr, opcode, instr_valid, done, instr_count
    );

endinterface
`default_nettype wire

// File: rtl/fetch_sequencer_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter with synchronous clear that sticks at all-ones
//                instead of wrapping. Clear has priority over increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             inc,
    input  wire logic             clr,
    output      logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count register: clear, saturating increment, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction-fetch front end. Owns the PC, addresses the
//                synchronous ROM, presents OPCODE/INSTR_VALID to Control and
//                applies the resolved branch/halt outcome (one bubble per
//                taken branch). Counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    fetch_sequencer_if.master bus
);

    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_next;
    logic             w_instr_valid;
    logic             w_done;
    logic             w_cnt_inc;
    logic             w_cnt_clr;
    logic [CNT_W-1:0] w_count;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC register; it is also the ROM read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Next-state logic: branch/halt only matter while a real instruction is shown.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_state_next = ST_PRIME;
                end
            end
            ST_PRIME: w_state_next = ST_RUN;
            ST_RUN: begin
                if (bus.halt) begin
                    w_state_next = ST_DONE;
                end else if (bus.branch_taken) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: w_state_next = ST_RUN;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Per-state outputs and PC/counter control; PC arithmetic wraps at PC_W bits.
    always_comb begin
        w_pc_next     = r_pc;
        w_instr_valid = 1'b0;
        w_done        = 1'b0;
        w_cnt_inc     = 1'b0;
        w_cnt_clr     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_done = (r_state == ST_DONE);
                if (bus.start) begin
                    w_pc_next = bus.start_addr;
                    w_cnt_clr = 1'b1;
                end
            end
            ST_PRIME: w_pc_next = r_pc + 1'b1;
            ST_RUN: begin
                w_instr_valid = 1'b1;
                w_cnt_inc     = 1'b1;
                if (bus.halt) begin
                    w_pc_next = r_pc;
                end else if (bus.branch_taken) begin
                    w_pc_next = bus.branch_target;
                end else begin
                    w_pc_next = r_pc + 1'b1;
                end
            end
            ST_FLUSH: w_pc_next = r_pc + 1'b1;
            default: ;
        endcase
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_instr_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_cnt_inc),
        .clr   (w_cnt_clr),
        .count (w_count)
    );

    assign bus.iaddr       = r_pc;
    assign bus.instr_valid = w_instr_valid;
    assign bus.opcode      = w_instr_valid ? bus.idata : NOP_OPCODE;
    assign bus.done        = w_done;
    assign bus.instr_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. A ROM and a small
//                datapath model surround two instances (16-bit and 4-bit
//                counters) that share every input; expected instruction
//                streams are queued and compared as instructions appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.PC_W(8), .CNT_W(16)) bus  ();
    fetch_sequencer_if #(.PC_W(8), .CNT_W(4))  bus4 ();

    fetch_sequencer #(.PC_W(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    fetch_sequencer #(.PC_W(8), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.master)
    );

    // ROM and datapath model
    logic [8:0] rom    [256];
    logic       br_en  [256];
    logic [7:0] br_tgt [256];
    logic [7:0] cur_addr;

    always @(posedge clk) begin
        bus.idata <= rom[bus.iaddr];
        cur_addr  <= bus.iaddr;
    end

    // Deliberately not gated by instr_valid: the DUT must ignore these itself.
    assign bus.halt          = (bus.idata == HALT_OPCODE);
    assign bus.branch_taken  = br_en[cur_addr];
    assign bus.branch_target = br_tgt[cur_addr];

    assign bus4.start         = bus.start;
    assign bus4.start_addr    = bus.start_addr;
    assign bus4.idata         = bus.idata;
    assign bus4.halt          = bus.halt;
    assign bus4.branch_taken  = bus.branch_taken;
    assign bus4.branch_target = bus.branch_target;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] addr;
        logic [8:0] op;
        int         cnt;
    } exp_t;

    exp_t sbq [$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic init_rom();
        for (int a = 0; a < 256; a++) begin
            rom[a]    = {1'b1, 8'(a)};
            br_en[a]  = 1'b0;
            br_tgt[a] = 8'h00;
        end
    endtask

    task automatic push_seq(input logic [7:0] a, input int n, input int c0);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = a + 8'(i);
            e.op   = rom[e.addr];
            e.cnt  = c0 + i;
            sbq.push_back(e);
        end
    endtask

    task automatic start_prog(input logic [7:0] a);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.start_addr = a;
        @(negedge clk);
        bus.start      = 1'b0;
        chk("prime_valid",   32'(bus.instr_valid), 32'd0);
        chk("prime_iaddr",   32'(bus.iaddr),       32'(a));
        chk("prime_done",    32'(bus.done),        32'd0);
        chk("prime_count",   32'(bus.instr_count), 32'd0);
        chk("prime_count4",  32'(bus4.instr_count), 32'd0);
    endtask

    task automatic wait_done(input logic [7:0] exp_iaddr, input int exp_cnt);
        int i = 0;
        while (!bus.done && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("done_reached", 32'(bus.done), 32'd1);
        chk("sb_drained",   32'(sbq.size()), 32'd0);
        chk("done_iaddr",   32'(bus.iaddr), 32'(exp_iaddr));
        chk("done_count",   32'(bus.instr_count), 32'(exp_cnt));
        @(negedge clk);
        chk("done_held",    32'(bus.done), 32'd1);
        chk("iaddr_frozen", 32'(bus.iaddr), 32'(exp_iaddr));
        sbq.delete();
    endtask

    // Monitor: compare each presented instruction with the queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.instr_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got opcode %0h from addr %0h, expected no instruction",
                             bus.opcode, cur_addr);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("sb_opcode",  32'(bus.opcode),       32'(mon_e.op));
                    chk("sb_addr",    32'(cur_addr),         32'(mon_e.addr));
                    chk("sb_count",   32'(bus.instr_count),  32'(mon_e.cnt));
                    chk("sb_count4",  32'(bus4.instr_count), 32'((mon_e.cnt > 15) ? 15 : mon_e.cnt));
                end
            end else begin
                chk("invalid_opcode_nop", 32'(bus.opcode), 32'(NOP_OPCODE));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.start_addr = 8'h00;
        init_rom();
        repeat (2) @(negedge clk);
        chk("rst_iaddr",  32'(bus.iaddr),       32'd0);
        chk("rst_opcode", 32'(bus.opcode),      32'd0);
        chk("rst_valid",  32'(bus.instr_valid), 32'd0);
        chk("rst_done",   32'(bus.done),        32'd0);
        chk("rst_count",  32'(bus.instr_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_valid", 32'(bus.instr_valid), 32'd0);

        // Branch 0x12 -> 0x40 with a HALT word on the wrong path at 0x13
        init_rom();
        rom[8'h13]    = HALT_OPCODE;
        rom[8'h43]    = HALT_OPCODE;
        br_en[8'h12]  = 1'b1;
        br_tgt[8'h12] = 8'h40;
        push_seq(8'h10, 3, 0);
        push_seq(8'h40, 4, 3);
        start_prog(8'h10);
        wait_done(8'h44, 7);

        // HALT at 0x15, then restart at 0x00 clears the count
        init_rom();
        rom[8'h15] = HALT_OPCODE;
        rom[8'h02] = HALT_OPCODE;
        push_seq(8'h10, 6, 0);
        start_prog(8'h10);
        wait_done(8'h16, 6);
        push_seq(8'h00, 3, 0);
        start_prog(8'h00);
        wait_done(8'h03, 3);

        // HALT and BRANCH_TAKEN together: HALT wins, no redirect
        init_rom();
        rom[8'h22]    = HALT_OPCODE;
        br_en[8'h22]  = 1'b1;
        br_tgt[8'h22] = 8'h80;
        push_seq(8'h20, 3, 0);
        start_prog(8'h20);
        wait_done(8'h23, 3);

        // PC wrap FE, FF, 00, 01
        init_rom();
        rom[8'h01] = HALT_OPCODE;
        push_seq(8'hFE, 4, 0);
        start_prog(8'hFE);
        wait_done(8'h02, 4);

        // Asynchronous reset mid-run
        init_rom();
        push_seq(8'h30, 3, 0);
        start_prog(8'h30);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_iaddr",  32'(bus.iaddr),        32'd0);
        chk("arst_opcode", 32'(bus.opcode),       32'd0);
        chk("arst_valid",  32'(bus.instr_valid),  32'd0);
        chk("arst_done",   32'(bus.done),         32'd0);
        chk("arst_count",  32'(bus.instr_count),  32'd0);
        chk("arst_count4", 32'(bus4.instr_count), 32'd0);
        chk("arst_sb",     32'(sbq.size()),       32'd0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(bus.instr_valid), 32'd0);
            chk("post_rst_iaddr", 32'(bus.iaddr),       32'd0);
        end

        // 20-instruction run: 4-bit counter saturates at F
        rom[8'h43] = HALT_OPCODE;
        push_seq(8'h30, 20, 0);
        start_prog(8'h30);
        wait_done(8'h44, 20);
        chk("sat_count4", 32'(bus4.instr_count), 32'h0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
